// File: rtl/tiny_dnn_regfile.sv
// AXI4-Lite slave register file for the tiny_dnn accelerator: CTRL/STATUS plus
// NREG-2 flat config words, independent AW/W holders and a 1-deep read pipe.
module tiny_dnn_regfile #(
  parameter  int NREG  = 32,
  parameter  int AW    = 8,
  localparam int CFG_W = (NREG-2)*32
) (
  input  logic             S_AXI_ACLK,
  input  logic             S_AXI_ARESETN,
  input  logic [31:0]      S_AXI_AWADDR,
  input  logic             S_AXI_AWVALID,
  output logic             S_AXI_AWREADY,
  input  logic [31:0]      S_AXI_WDATA,
  input  logic [3:0]       S_AXI_WSTRB,
  input  logic             S_AXI_WVALID,
  output logic             S_AXI_WREADY,
  output logic [1:0]       S_AXI_BRESP,
  output logic             S_AXI_BVALID,
  input  logic             S_AXI_BREADY,
  input  logic [31:0]      S_AXI_ARADDR,
  input  logic             S_AXI_ARVALID,
  output logic             S_AXI_ARREADY,
  output logic [31:0]      S_AXI_RDATA,
  output logic [1:0]       S_AXI_RRESP,
  output logic             S_AXI_RVALID,
  input  logic             S_AXI_RREADY,
  output logic             start,
  output logic [6:0]       mode,
  output logic [CFG_W-1:0] cfg,
  input  logic             busy_i,
  input  logic             done_i,
  output logic             irq
);
  localparam int IW = $clog2(NREG);
  localparam logic [AW-2:0] LIM = NREG[AW-2:0];

  // Out-of-window bits or an index past the last register both decode to SLVERR.
  function automatic logic dec_err(input logic [31:0] a);
    return (|a[31:AW]) || ({1'b0, a[AW-1:2]} >= LIM);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = s[b] ? d[b*8 +: 8] : o[b*8 +: 8];
    return m;
  endfunction

  logic                    r_aw_full, r_aw_err, r_w_full, r_bvalid;
  logic [IW-1:0]           r_aw_idx;
  logic [31:0]             r_wdata;
  logic [3:0]              r_wstrb;
  logic [1:0]              r_bresp;
  logic                    r_rvalid;
  logic [31:0]             r_rdata;
  logic [1:0]              r_rresp;
  logic [6:0]              r_mode;
  logic                    r_ie, r_done, r_start, r_irq;
  logic [NREG-3:0][31:0]   r_cfg;

  logic          w_awready, w_wready, w_commit, w_wr_ok, w_ctrl_wr, w_stat_wr, w_done_clr;
  logic [IW-1:0] w_ar_idx;
  logic          w_ar_err;
  logic [31:0]   w_rdata;
  logic          w_unused;

  assign w_awready  = !r_aw_full && !r_bvalid;
  assign w_wready   = !r_w_full && !r_bvalid;
  assign w_commit   = r_aw_full && r_w_full;
  assign w_wr_ok    = w_commit && !r_aw_err;
  assign w_ctrl_wr  = w_wr_ok && (r_aw_idx == '0) && r_wstrb[0];
  assign w_stat_wr  = w_wr_ok && (r_aw_idx == IW'(1)) && r_wstrb[0];
  assign w_done_clr = w_stat_wr && r_wdata[1];
  assign w_ar_idx   = S_AXI_ARADDR[IW+1:2];
  assign w_ar_err   = dec_err(S_AXI_ARADDR);
  assign w_unused   = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_aw_full <= 1'b0;
      r_aw_err  <= 1'b0;
      r_aw_idx  <= '0;
      r_w_full  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
    end else begin
      if (w_commit) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= r_aw_err ? 2'b10 : 2'b00;
      end else begin
        if (S_AXI_AWVALID && w_awready) begin
          r_aw_full <= 1'b1;
          r_aw_idx  <= S_AXI_AWADDR[IW+1:2];
          r_aw_err  <= dec_err(S_AXI_AWADDR);
        end
        if (S_AXI_WVALID && w_wready) begin
          r_w_full <= 1'b1;
          r_wdata  <= S_AXI_WDATA;
          r_wstrb  <= S_AXI_WSTRB;
        end
      end
      if (r_bvalid && S_AXI_BREADY) r_bvalid <= 1'b0;
    end
  end

  // done_i is OR'd last so a same-cycle W1C never loses a completion.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_mode  <= '0;
      r_ie    <= 1'b0;
      r_done  <= 1'b0;
      r_start <= 1'b0;
      r_irq   <= 1'b0;
      r_cfg   <= '0;
    end else begin
      r_start <= w_ctrl_wr && r_wdata[0];
      if (w_ctrl_wr) r_mode <= r_wdata[7:1];
      if (w_stat_wr) r_ie <= r_wdata[2];
      r_done <= done_i || (r_done && !w_done_clr);
      r_irq  <= r_done && r_ie;
      for (int k = 2; k < NREG; k++)
        if (w_wr_ok && (r_aw_idx == IW'(k))) r_cfg[k-2] <= merge(r_cfg[k-2], r_wdata, r_wstrb);
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_ar_idx == '0)          w_rdata = {24'd0, r_mode, 1'b0};
    else if (w_ar_idx == IW'(1)) w_rdata = {29'd0, r_ie, r_done, busy_i};
    else                         w_rdata = r_cfg[w_ar_idx - IW'(2)];
    if (w_ar_err) w_rdata = '0;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= 2'b00;
    end else if (S_AXI_ARVALID && !r_rvalid) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rdata;
      r_rresp  <= w_ar_err ? 2'b10 : 2'b00;
    end else if (r_rvalid && S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  assign S_AXI_AWREADY = w_awready;
  assign S_AXI_WREADY  = w_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = !r_rvalid;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign start         = r_start;
  assign mode          = r_mode;
  assign cfg           = r_cfg;
  assign irq           = r_irq;
endmodule
